// File: rtl/image_pkg.sv
// Shared definitions for the camera capture and image processing blocks.
//   PIX_W   : width of one raw Bayer sample
//   COORD_W : width of the X / Y pixel coordinates
//   pixel_t : one raw pixel
//   coord_t : one coordinate
package image_pkg;
    localparam int PIX_W   = 12;
    localparam int COORD_W = 11;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/xy_counter.sv
// Next-pixel coordinate generator for the capture path.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   inc      : a pixel was accepted this cycle, advance to the next position
//   clr      : frame ended, return to (0,0); wins over inc
//   nx, ny   : coordinate the next accepted pixel will be tagged with
// X wraps at H_ACTIVE-1 and carries into Y; Y wraps modulo 2^COORD_W.
module xy_counter
    import image_pkg::*;
#(
    parameter int H_ACTIVE = 1280
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   clr,
    output coord_t nx,
    output coord_t ny
);

    localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            nx <= '0;
            ny <= '0;
        end else if (inc) begin
            if (nx == X_LAST) begin
                nx <= '0;
                ny <= ny + coord_t'(1);
            end else begin
                nx <= nx + coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/raw_pixel_capture.sv
// Sensor raw-interface capture: turns frame/line valid plus 12-bit Bayer data
// into a coordinate-tagged pixel stream, gated by start/stop pulses.
// Ports:
//   iCLK, iRST    : sensor pixel clock, synchronous active-high reset
//   iDATA         : raw Bayer pixel
//   iFVAL, iLVAL  : sensor frame valid / line valid
//   iSTART, iEND  : one-cycle arm / disarm pulses (iEND wins if both)
//   oDATA, oDVAL  : captured pixel and its valid (oDATA is 0 when not valid)
//   oX_Cont       : column of the pixel on oDATA
//   oY_Cont       : row of the pixel on oDATA
//   oFrame_Cont   : frames accepted since reset, wraps modulo 2^32
//
// Output stream semantics: oDVAL is a valid-only qualifier with no ready.
// Every cycle with oDVAL=1 carries exactly one pixel that the consumer must
// take; there is no back-pressure, and pixels arrive two cycles after the
// sensor presents them.
module raw_pixel_capture
    import image_pkg::*;
#(
    parameter int H_ACTIVE = 1280
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iDATA,
    input  logic        iFVAL,
    input  logic        iLVAL,
    input  logic        iSTART,
    input  logic        iEND,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont
);

    pixel_t d_DATA;
    logic   d_FVAL;
    logic   d_LVAL;
    logic   armed;
    logic   fact;
    coord_t nx;
    coord_t ny;

    logic frame_rise;
    logic frame_fall;
    logic accept;

    // Edges compare the live input against its registered copy so the
    // first pixel of a frame (FVAL and LVAL rising together) is not lost.
    assign frame_rise = iFVAL & ~d_FVAL;
    assign frame_fall = ~iFVAL & d_FVAL;
    assign accept     = fact & d_LVAL;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            d_DATA      <= '0;
            d_FVAL      <= 1'b0;
            d_LVAL      <= 1'b0;
            armed       <= 1'b0;
            fact        <= 1'b0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
        end else begin
            d_DATA <= iDATA;
            d_FVAL <= iFVAL;
            d_LVAL <= iLVAL;

            if (iEND) begin
                armed <= 1'b0;
            end else if (iSTART) begin
                armed <= 1'b1;
            end

            // A frame is accepted or rejected once, at its rise; disarming
            // mid-frame lets the current frame run to completion.
            if (frame_rise) begin
                fact <= armed;
                if (armed) begin
                    oFrame_Cont <= oFrame_Cont + 32'd1;
                end
            end else if (frame_fall) begin
                fact <= 1'b0;
            end

            if (accept) begin
                oDVAL   <= 1'b1;
                oDATA   <= d_DATA;
                oX_Cont <= nx;
                oY_Cont <= ny;
            end else begin
                oDVAL   <= 1'b0;
                oDATA   <= '0;
            end
        end
    end

    xy_counter #(
        .H_ACTIVE (H_ACTIVE)
    ) u_xy_counter (
        .clk (iCLK),
        .rst (iRST),
        .inc (accept),
        .clr (frame_fall),
        .nx  (nx),
        .ny  (ny)
    );

endmodule

// File: tb/tb_raw_pixel_capture.sv
// Bench for raw_pixel_capture with H_ACTIVE=4: a hand-computed vector table
// for the basic frame, directed multi-cycle sequences, and randomized frames,
// all checked against a frame/pixel-index reference model.
module tb_raw_pixel_capture;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] data = '0;
    logic        fval = 1'b0;
    logic        lval = 1'b0;
    logic        st = 1'b0;
    logic        en = 1'b0;
    logic [11:0] o_data;
    logic        o_dval;
    logic [10:0] o_x;
    logic [10:0] o_y;
    logic [31:0] o_cnt;

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    raw_pixel_capture #(
        .H_ACTIVE (H)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iDATA       (data),
        .iFVAL       (fval),
        .iLVAL       (lval),
        .iSTART      (st),
        .iEND        (en),
        .oDATA       (o_data),
        .oDVAL       (o_dval),
        .oX_Cont     (o_x),
        .oY_Cont     (o_y),
        .oFrame_Cont (o_cnt)
    );

    // ---------------- reference model ----------------
    // A frame is accepted iff the arm flag was set before the cycle its
    // frame-valid rose. Accepted pixels are numbered within their frame;
    // pixel n sits at (n mod H, n div H) and appears two cycles later.
    bit          m_armed     = 0;
    bit          m_prev_fval = 0;
    bit          m_frame_ok  = 0;
    int          m_idx       = 0;
    logic [31:0] m_cnt       = '0;
    logic [11:0] pend_q[$];   // pixel data due out after the next edge
    logic [21:0] pend_xy[$];  // matching {x, y}
    logic        e_dval = 0;
    logic [11:0] e_data = '0;
    logic [10:0] e_x = '0;
    logic [10:0] e_y = '0;

    task automatic model_edge(input logic r, input logic f, input logic l,
                              input logic [11:0] d, input logic s, input logic e);
        logic [21:0] xy;
        if (r) begin
            m_armed = 0; m_prev_fval = 0; m_frame_ok = 0; m_idx = 0;
            m_cnt = '0; pend_q.delete(); pend_xy.delete();
            e_dval = 0; e_data = '0; e_x = '0; e_y = '0;
        end else begin
            if (pend_q.size() != 0) begin
                xy = pend_xy.pop_front();
                e_dval = 1; e_data = pend_q.pop_front();
                e_x = xy[21:11]; e_y = xy[10:0];
            end else begin
                e_dval = 0; e_data = '0;
            end
            if (f && !m_prev_fval) begin
                m_frame_ok = m_armed;
                m_idx = 0;
                if (m_armed) m_cnt = m_cnt + 32'd1;
            end
            if (!f && m_prev_fval) m_frame_ok = 0;
            if (f && l && m_frame_ok) begin
                pend_q.push_back(d);
                pend_xy.push_back({11'(m_idx % H), 11'((m_idx / H) % 2048)});
                m_idx++;
            end
            if (e) m_armed = 0;
            else if (s) m_armed = 1;
            m_prev_fval = f;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycle, got, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, check at negedge.
    task automatic step(input logic r, input logic f, input logic l,
                        input logic [11:0] d, input logic s, input logic e);
        rst = r; fval = f; lval = l; data = d; st = s; en = e;
        @(posedge clk);
        model_edge(r, f, l, d, s, e);
        @(negedge clk);
        cycle++;
        check("dval",  32'(o_dval), 32'(e_dval));
        check("data",  32'(o_data), 32'(e_data));
        check("x",     32'(o_x),    32'(e_x));
        check("y",     32'(o_y),    32'(e_y));
        check("count", o_cnt,       m_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 12'h0, 0, 0);
    endtask

    // Frame of 'lines' lines of 'len' pixels, one-cycle line gaps, FVAL and
    // LVAL dropping together at the end. iEND pulses on the first pixel of
    // end_line. With rnd set, start/end/reset pulses are sprinkled randomly.
    task automatic frame(input int lines, input int len, input int end_line, input bit rnd);
        logic r, s, e;
        for (int li = 0; li < lines; li++) begin
            for (int p = 0; p < len; p++) begin
                r = rnd && ($urandom_range(0, 299) == 0);
                s = rnd && ($urandom_range(0, 7) == 0);
                e = (rnd && ($urandom_range(0, 11) == 0)) || (li == end_line && p == 0);
                step(r, 1, 1, 12'($urandom_range(0, 4095)), s, e);
            end
            if (li != lines - 1) step(0, 1, 0, 12'($urandom_range(0, 4095)), 0, 0);
        end
        step(0, 0, 0, 12'($urandom_range(0, 4095)), 0, 0);
    endtask

    typedef struct {
        logic        f, l;
        logic [11:0] d;
        logic        s;
        logic        dv;
        logic [11:0] od;
        logic [10:0] x, y;
        logic [31:0] cnt;
    } vec_t;

    vec_t tv[12];

    initial begin
        // Basic frame: 2 lines x 4 pixels, data 1..8; outputs after each edge.
        tv[0]  = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 12'd0, 11'd0, 11'd0, 32'd0};
        tv[1]  = '{1'b1, 1'b1, 12'd1, 1'b0, 1'b0, 12'd0, 11'd0, 11'd0, 32'd1};
        tv[2]  = '{1'b1, 1'b1, 12'd2, 1'b0, 1'b1, 12'd1, 11'd0, 11'd0, 32'd1};
        tv[3]  = '{1'b1, 1'b1, 12'd3, 1'b0, 1'b1, 12'd2, 11'd1, 11'd0, 32'd1};
        tv[4]  = '{1'b1, 1'b1, 12'd4, 1'b0, 1'b1, 12'd3, 11'd2, 11'd0, 32'd1};
        tv[5]  = '{1'b1, 1'b0, 12'd0, 1'b0, 1'b1, 12'd4, 11'd3, 11'd0, 32'd1};
        tv[6]  = '{1'b1, 1'b1, 12'd5, 1'b0, 1'b0, 12'd0, 11'd3, 11'd0, 32'd1};
        tv[7]  = '{1'b1, 1'b1, 12'd6, 1'b0, 1'b1, 12'd5, 11'd0, 11'd1, 32'd1};
        tv[8]  = '{1'b1, 1'b1, 12'd7, 1'b0, 1'b1, 12'd6, 11'd1, 11'd1, 32'd1};
        tv[9]  = '{1'b1, 1'b1, 12'd8, 1'b0, 1'b1, 12'd7, 11'd2, 11'd1, 32'd1};
        tv[10] = '{1'b0, 1'b0, 12'd0, 1'b0, 1'b1, 12'd8, 11'd3, 11'd1, 32'd1};
        tv[11] = '{1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 11'd3, 11'd1, 32'd1};

        @(negedge clk);

        // Reset with random inputs, then an unarmed frame is ignored.
        for (int i = 0; i < 2; i++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(2);
        frame(2, 4, -1, 0);
        idle(2);
        check("unarmed_count", o_cnt, 32'd0);

        // Table-driven basic frame.
        for (int i = 0; i < 12; i++) begin
            step(0, tv[i].f, tv[i].l, tv[i].d, tv[i].s, 0);
            check("tbl_dval",  32'(o_dval), 32'(tv[i].dv));
            check("tbl_data",  32'(o_data), 32'(tv[i].od));
            check("tbl_x",     32'(o_x),    32'(tv[i].x));
            check("tbl_y",     32'(o_y),    32'(tv[i].y));
            check("tbl_count", o_cnt,       tv[i].cnt);
        end

        // Line overrun, then a normal frame that must restart at (0,0).
        frame(1, 6, -1, 0);
        idle(1);
        check("overrun_last_x", 32'(o_x), 32'd1);
        check("overrun_last_y", 32'(o_y), 32'd1);
        frame(1, 4, -1, 0);
        idle(1);
        check("after_overrun_y", 32'(o_y), 32'd0);

        // iEND during line 1: frame completes, next frame rejected.
        frame(3, 4, 1, 0);
        idle(2);
        check("end_mid_count", o_cnt, 32'd4);
        frame(2, 4, -1, 0);
        idle(2);
        check("end_next_count", o_cnt, 32'd4);

        // Simultaneous pulses leave capture disarmed; START alone re-arms.
        step(0, 0, 0, 12'h0, 1, 1);
        frame(2, 4, -1, 0);
        idle(1);
        check("both_count", o_cnt, 32'd4);
        step(0, 0, 0, 12'h0, 1, 0);
        frame(2, 4, -1, 0);
        idle(1);
        check("rearm_count", o_cnt, 32'd5);

        // Reset at pixel 2 of line 0; a START mid-frame does not revive it.
        step(0, 0, 0, 12'h0, 1, 0);
        step(0, 1, 1, 12'h111, 0, 0);
        step(0, 1, 1, 12'h222, 0, 0);
        step(1, 1, 1, 12'h333, 0, 0);
        check("rst_mid_dval", 32'(o_dval), 32'd0);
        check("rst_mid_count", o_cnt, 32'd0);
        step(0, 1, 1, 12'h444, 1, 0);
        step(0, 1, 0, 12'h555, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 12'(i + 6), 0, 0);
        step(0, 0, 0, 12'h0, 0, 0);
        frame(2, 4, -1, 0);
        idle(1);
        check("rst_next_count", o_cnt, 32'd1);

        // Randomized frames with random control pulses and occasional reset.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) step(0, 0, 0, 12'h0, 1, 0);
            frame($urandom_range(1, 3), $urandom_range(1, 7), -1, 1);
            idle($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/raw_pixel_capture.md
# raw_pixel_capture

Converts the camera sensor's raw parallel interface (frame valid, line valid, 12-bit Bayer data) into the coordinate-tagged pixel stream consumed by `image_processing`. Produces `oDATA`, `oDVAL`, `oX_Cont` and `oY_Cont`. Capture is gated by start/stop pulses from the control path. A running count of captured frames is kept for the display and status logic. Sits between the sensor I/O pins and the greyscale/filter pipeline, in the sensor pixel-clock domain.

## Interface
- `H_ACTIVE`, default 1280: active pixels per line; the X coordinate wraps at `H_ACTIVE-1`.
- `iCLK` in 1: sensor pixel clock; the only clock.
- `iRST` in 1: reset; synchronous, active-high.
- `iDATA` in 12: raw Bayer pixel from the sensor.
- `iFVAL` in 1: sensor frame valid.
- `iLVAL` in 1: sensor line valid.
- `iSTART` in 1: one-cycle pulse; arms capture.
- `iEND` in 1: one-cycle pulse; disarms capture.
- `oDATA` out 12: captured pixel; 0 when `oDVAL` is low.
- `oDVAL` out 1: pixel valid.
- `oX_Cont` out 11: column of the pixel on `oDATA`.
- `oY_Cont` out 11: row of the pixel on `oDATA`.
- `oFrame_Cont` out 32: number of frames accepted since reset.

## Operation
- **Input stage.** `iDATA`, `iFVAL` and `iLVAL` are registered every cycle into `d_DATA`, `d_FVAL` and `d_LVAL`.
- **Arm flag `armed`.**
  - Set by `iSTART`, cleared by `iEND`.
  - If both pulse in the same cycle, `iEND` wins (`armed` = 0).
- **Frame-active flag `fact`** (registered):
  - Frame rise is `iFVAL & ~d_FVAL`; frame fall is `~iFVAL & d_FVAL`.
  - On frame rise with `armed`=1 (value before the current edge): `fact` <= 1 and `oFrame_Cont` increments.
  - On frame rise with `armed`=0: the frame is ignored; `fact` stays 0 and the counter is unchanged.
  - On frame fall: `fact` <= 0.
  - `iEND` in mid-frame does not clear `fact`. The current frame completes; the next rise is rejected.
- **Pixel acceptance.** A pixel is accepted when `fact & d_LVAL`. On acceptance:
  - `oDVAL` <= 1 and `oDATA` <= `d_DATA`.
  - `oX_Cont` <= `nx` and `oY_Cont` <= `ny`, where `nx`/`ny` are the internal next-coordinate counters.
  - If `nx == H_ACTIVE-1`: `nx` <= 0 and `ny` <= `ny+1`. Otherwise `nx` <= `nx+1`.
  - `ny` wraps modulo 2048.
- **No acceptance.** `oDVAL` <= 0 and `oDATA` <= 0. `oX_Cont`/`oY_Cont` hold their last values.
- **Frame fall.** `nx` and `ny` <= 0, so every frame starts at (0,0). Lines shorter than `H_ACTIVE` do not advance `ny`; the row counter advances only on an X wrap.
- **Counter width.** `oFrame_Cont` wraps modulo 2^32.
- **Reset.** Clears all state and outputs to 0: `armed`, `fact`, `d_*`, `nx`, `ny`, `oDATA`, `oDVAL`, `oX_Cont`, `oY_Cont`, `oFrame_Cont`. Reset mid-frame aborts the frame; after reset, capture needs a fresh `iSTART` and a fresh `iFVAL` rise.

## Timing
- **Latency.** Sensor pixel sampled at edge k (with `iFVAL`/`iLVAL` high) appears on `oDATA` with `oDVAL`=1 after edge k+2. There is a fixed 2-cycle latency with no gaps and no back-pressure; one pixel per clock is sustained.
- **First pixel.** If `iFVAL` rises at edge k together with `iLVAL`, the pixel sampled at k is accepted.
- **Arming.** `iSTART` asserted in the cycle before edge k is sufficient to accept a frame rising at edge k. `iSTART` at the same edge as the rise is too late.
- **Gaps.** `oDVAL` drops exactly 2 cycles after `iLVAL` or `iFVAL` drops.
- **Frame counter.** `oFrame_Cont` updates 1 cycle after the rise is sampled, i.e. at edge k+1.

## Structure
- Shared package `image_pkg`:
  - `PIX_W` = 12 and `COORD_W` = 11.
  - Typedef `pixel_t` = logic [PIX_W-1:0] and typedef `coord_t` = logic [COORD_W-1:0], shared with `image_processing`.
- One sub-module, `xy_counter` (holds `nx`/`ny`):
  - Inputs: `inc`, `clr`.
  - Parameter: `H_ACTIVE`.
  - Behaviour: wraps X and increments Y. `clr` has priority over `inc`.

## Test plan
- **Reset values.** Assert `iRST` for 2 cycles with random inputs -> all outputs 0. After release with no `iSTART`, a full `iFVAL`/`iLVAL` frame -> `oDVAL` never 1, `oFrame_Cont` = 0.
- **Basic frame.** `H_ACTIVE`=4; pulse `iSTART`; frame of 2 lines × 4 pixels, data 1..8 -> 8 `oDVAL` cycles with data 1..8, coordinates (0,0)..(3,0),(0,1)..(3,1), each 2 cycles after input; `oFrame_Cont` = 1.
- **Line overrun.** `H_ACTIVE`=4; a 6-pixel line -> coordinates (0,0),(1,0),(2,0),(3,0),(0,1),(1,1). The next frame starts at (0,0).
- **`iEND` mid-frame.** `iEND` on line 1 of frame 1 -> frame 1 completes all pixels. Frame 2 -> no `oDVAL`; `oFrame_Cont` stays 1.
- **Simultaneous pulses.** `iSTART` and `iEND` in the same cycle -> `armed` = 0, next frame ignored. Then `iSTART` alone -> the following frame is accepted.
- **Reset mid-frame.** `iRST` during line 0 at pixel 2 -> outputs 0 from the next edge. The remainder of the frame is ignored even after a new `iSTART`; the next full frame starts at (0,0).
